// File: rtl/jury_vote_controller_pkg.sv
// Shared constants for the jury voting round: vote codes, verdict codes,
// FSM state encoding and the tally width derivation.
package jury_vote_controller_pkg;

    localparam logic [1:0] VOTE_ABSTAIN = 2'b00;
    localparam logic [1:0] VOTE_AGAINST = 2'b01;
    localparam logic [1:0] VOTE_FAVOUR  = 2'b10;
    localparam logic [1:0] VOTE_INVALID = 2'b11;

    localparam logic [1:0] VERDICT_NONE     = 2'b00;
    localparam logic [1:0] VERDICT_REJECTED = 2'b01;
    localparam logic [1:0] VERDICT_APPROVED = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_TALLY   = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    // Width that can hold every value 0..n so tallies never wrap.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/jury_vote_controller_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests, searching from the
// index after the last granted requester.
module rr_arbiter
    import jury_vote_controller_pkg::*;
#(
    parameter int unsigned N = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_c_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gidx_c;
    logic          found_c;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        logic [PW:0] sum;
        grant_c_o = '0;
        found_c   = 1'b0;
        gidx_c    = ptr_q;
        for (int unsigned off = 0; off < N; off++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            if (!found_c && req_i[sum[PW-1:0]]) begin
                found_c                  = 1'b1;
                gidx_c                   = sum[PW-1:0];
                grant_c_o[sum[PW-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i && found_c) begin
            ptr_d = (gidx_c == PW'(N - 1)) ? '0 : gidx_c + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/jury_vote_controller.sv
// One jury voting round: arbitrates juror requests, accepts one vote per
// juror, tallies favour/against/abstain and publishes a verdict.
module jury_vote_controller
    import jury_vote_controller_pkg::*;
#(
    parameter int unsigned N_JURORS = 4,
    parameter int unsigned TIMEOUT  = 200,
    localparam int unsigned CW      = count_width(N_JURORS)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_JURORS-1:0]   vote_req,
    input  logic [2*N_JURORS-1:0] vote_code,
    output logic [N_JURORS-1:0]   vote_ack,
    output logic [N_JURORS-1:0]   voted,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         yes_count,
    output logic [CW-1:0]         no_count,
    output logic [CW-1:0]         abst_count,
    output logic [1:0]            verdict
);

    localparam int unsigned  TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]          state_q,   state_d;
    logic [N_JURORS-1:0] voted_q,   voted_d;
    logic [N_JURORS-1:0] ack_q,     ack_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [CW-1:0]       yes_q,     yes_d;
    logic [CW-1:0]       no_q,      no_d;
    logic [CW-1:0]       abst_q,    abst_d;
    logic [1:0]          verdict_q, verdict_d;
    logic [TW-1:0]       timer_q,   timer_d;

    logic                in_collect_c;
    logic                round_start_c;
    logic [N_JURORS-1:0] eligible_c;
    logic [N_JURORS-1:0] grant_c;
    logic [1:0]          code_sel_c;
    logic [CW-1:0]       missing_c;

    assign in_collect_c  = (state_q == ST_COLLECT);
    assign round_start_c = (state_q == ST_IDLE) && start;
    assign eligible_c    = in_collect_c ? (vote_req & ~voted_q) : '0;

    rr_arbiter #(
        .N (N_JURORS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (round_start_c),
        .en_i      (in_collect_c),
        .req_i     (eligible_c),
        .grant_c_o (grant_c)
    );

    // Code of the granted juror, and the number of jurors who never voted.
    always_comb begin
        code_sel_c = VOTE_ABSTAIN;
        missing_c  = '0;
        for (int unsigned i = 0; i < N_JURORS; i++) begin
            if (grant_c[i]) begin
                code_sel_c = vote_code[2*i +: 2];
            end
            missing_c = missing_c + CW'(!voted_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        voted_d   = voted_q;
        ack_d     = '0;
        yes_d     = yes_q;
        no_d      = no_q;
        abst_d    = abst_q;
        verdict_d = verdict_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_COLLECT;
                    voted_d   = '0;
                    timer_d   = '0;
                    yes_d     = '0;
                    no_d      = '0;
                    abst_d    = '0;
                    verdict_d = VERDICT_NONE;
                end
            end
            ST_COLLECT: begin
                ack_d   = grant_c;
                voted_d = voted_q | grant_c;
                timer_d = timer_q + TW'(1);
                if (|grant_c) begin
                    case (code_sel_c)
                        VOTE_FAVOUR:  yes_d  = yes_q + CW'(1);
                        VOTE_AGAINST: no_d   = no_q + CW'(1);
                        default:      abst_d = abst_q + CW'(1);
                    endcase
                end
                // A grant in the final timer cycle is still counted above.
                if ((&voted_q) || (timer_q == TIMER_LAST)) begin
                    state_d = ST_TALLY;
                end
            end
            ST_TALLY: begin
                abst_d = abst_q + missing_c;
                if (yes_q > no_q) begin
                    verdict_d = VERDICT_APPROVED;
                end else if (no_q > yes_q) begin
                    verdict_d = VERDICT_REJECTED;
                end else begin
                    verdict_d = VERDICT_NONE;
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == ST_COLLECT) || (state_d == ST_TALLY);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            voted_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            yes_q     <= '0;
            no_q      <= '0;
            abst_q    <= '0;
            verdict_q <= VERDICT_NONE;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            voted_q   <= voted_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            yes_q     <= yes_d;
            no_q      <= no_d;
            abst_q    <= abst_d;
            verdict_q <= verdict_d;
            timer_q   <= timer_d;
        end
    end

    assign vote_ack   = ack_q;
    assign voted      = voted_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign yes_count  = yes_q;
    assign no_count   = no_q;
    assign abst_count = abst_q;
    assign verdict    = verdict_q;

endmodule

// File: tb/tb_jury_vote_controller.sv
// Self-checking bench for jury_vote_controller: scoreboard of expected acks
// and round results, compared as the DUT produces them.
module tb_jury_vote_controller;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 10;
    localparam int unsigned CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   vote_req;
    logic [2*N-1:0] vote_code;
    logic [N-1:0]   vote_ack;
    logic [N-1:0]   voted;
    logic           busy;
    logic           done;
    logic [CW-1:0]  yes_count;
    logic [CW-1:0]  no_count;
    logic [CW-1:0]  abst_count;
    logic [1:0]     verdict;

    always #5 clk = ~clk;

    jury_vote_controller #(
        .N_JURORS (N),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vote_req   (vote_req),
        .vote_code  (vote_code),
        .vote_ack   (vote_ack),
        .voted      (voted),
        .busy       (busy),
        .done       (done),
        .yes_count  (yes_count),
        .no_count   (no_count),
        .abst_count (abst_count),
        .verdict    (verdict)
    );

    typedef struct packed {
        logic [CW-1:0] y;
        logic [CW-1:0] n;
        logic [CW-1:0] a;
        logic [1:0]    v;
    } res_t;

    int checks   = 0;
    int failures = 0;

    int   exp_ack[$];
    int   obs_ack[$];
    int   obs_cyc[$];
    res_t exp_res[$];

    int           done_at;
    bit           timed_out;
    res_t         obs_res;
    logic [N-1:0] obs_voted;

    // Reference tally: jurors outside mask, abstain and invalid all count as abstain.
    function automatic res_t model(input logic [2*N-1:0] codes, input logic [N-1:0] mask);
        res_t       r;
        int         y;
        int         n;
        int         a;
        logic [1:0] c;
        y = 0; n = 0; a = 0;
        for (int i = 0; i < N; i++) begin
            c = 2'(codes >> (2*i));
            if (!mask[i])          a++;
            else if (c == 2'b10)   y++;
            else if (c == 2'b01)   n++;
            else                   a++;
        end
        r.y = CW'(y);
        r.n = CW'(n);
        r.a = CW'(a);
        r.v = (y > n) ? 2'b10 : ((n > y) ? 2'b01 : 2'b00);
        return r;
    endfunction

    function automatic string rs(input res_t r);
        return $sformatf("y=%0d n=%0d a=%0d v=%b", r.y, r.n, r.a, r.v);
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic res_t cur_res();
        res_t r;
        r.y = yes_count;
        r.n = no_count;
        r.a = abst_count;
        r.v = verdict;
        return r;
    endfunction

    // Drives one round from IDLE; jurors drop requests once acked unless held.
    task automatic run_round(input logic [N-1:0] init_req, input logic [2*N-1:0] codes,
                             input logic [N-1:0] hold_mask, input int late_j,
                             input int late_c, input int max_c);
        obs_ack.delete();
        obs_cyc.delete();
        timed_out = 1'b1;
        done_at   = -1;
        @(negedge clk);
        vote_code = codes;
        vote_req  = init_req;
        start     = 1'b1;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (vote_ack != '0) begin
                obs_ack.push_back(onehot_idx(vote_ack));
                obs_cyc.push_back(c);
                vote_req = vote_req & (~vote_ack | hold_mask);
            end
            if (done) begin
                done_at   = c;
                obs_res   = cur_res();
                obs_voted = voted;
                timed_out = 1'b0;
                break;
            end
            if (late_j >= 0 && c == late_c) vote_req = vote_req | (N'(1) << late_j);
        end
        vote_req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vote_req = '0; vote_code = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vote_ack, voted, busy, done, yes_count, no_count, abst_count, verdict} !== '0) begin
            failures++;
            $display("FAIL reset_hold: ack=%b voted=%b busy=%b done=%b %s", vote_ack, voted, busy, done, rs(cur_res()));
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({vote_ack, voted, busy, done, yes_count, no_count, abst_count, verdict} !== '0) begin
            failures++;
            $display("FAIL reset_idle: ack=%b voted=%b busy=%b done=%b %s", vote_ack, voted, busy, done, rs(cur_res()));
        end
    endtask

    task automatic test_basic();
        logic [2*N-1:0] codes;
        int             exp_c[$];
        int             e, o, idx, last;
        res_t           r;
        codes = {2'b00, 2'b01, 2'b10, 2'b10};
        exp_ack = '{0, 1, 2, 3};
        exp_c   = '{2, 3, 4, 5};
        exp_res.push_back(model(codes, 4'b1111));
        run_round(4'b1111, codes, '0, -1, 0, 40);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_done: got no done want done"); end
        last = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : -100;
        idx = 0;
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            checks++;
            if (obs_ack.size() == 0) begin
                failures++; $display("FAIL basic_ack: got none want juror %0d", e);
            end else begin
                o = obs_ack.pop_front();
                if (o !== e || obs_cyc[idx] !== exp_c[idx]) begin
                    failures++;
                    $display("FAIL basic_ack: got juror %0d at cycle %0d want juror %0d at cycle %0d", o, obs_cyc[idx], e, exp_c[idx]);
                end
            end
            idx++;
        end
        checks++;
        if (done_at !== last + 2) begin failures++; $display("FAIL basic_done_lat: got %0d want %0d", done_at, last + 2); end
        r = exp_res.pop_front();
        checks++;
        if (obs_res !== r) begin failures++; $display("FAIL basic_result: got %s want %s", rs(obs_res), rs(r)); end
        // Results must hold in IDLE until the next start.
        @(negedge clk);
        checks++;
        if (cur_res() !== r || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL basic_hold: got %s busy=%b done=%b want %s busy=0 done=0", rs(cur_res()), busy, done, rs(r));
        end
    endtask

    task automatic test_rehold();
        logic [2*N-1:0] codes;
        int             e, o;
        res_t           r;
        codes = {2'b00, 2'b10, 2'b00, 2'b00};
        exp_ack = '{2, 0};
        exp_res.push_back(model(codes, 4'b0101));
        run_round(4'b0100, codes, 4'b0100, 0, 4, 40);
        checks++;
        if (obs_ack.size() != 2) begin failures++; $display("FAIL rehold_count: got %0d acks want 2", obs_ack.size()); end
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            o = (obs_ack.size() > 0) ? obs_ack.pop_front() : -1;
            checks++;
            if (o !== e) begin failures++; $display("FAIL rehold_ack: got juror %0d want juror %0d", o, e); end
        end
        checks++;
        if (obs_voted !== 4'b0101) begin failures++; $display("FAIL rehold_voted: got %b want 0101", obs_voted); end
        checks++;
        if (done_at !== int'(TO) + 2) begin failures++; $display("FAIL rehold_done: got %0d want %0d", done_at, TO + 2); end
        r = exp_res.pop_front();
        checks++;
        if (obs_res !== r) begin failures++; $display("FAIL rehold_result: got %s want %s", rs(obs_res), rs(r)); end
    endtask

    task automatic test_timeout();
        logic [2*N-1:0] codes;
        int             o;
        res_t           r;
        codes = {2'b00, 2'b00, 2'b01, 2'b00};
        exp_ack = '{1};
        exp_res.push_back(model(codes, 4'b0010));
        run_round(4'b0010, codes, '0, -1, 0, 40);
        o = (obs_ack.size() == 1) ? obs_ack[0] : -1;
        checks++;
        if (o !== exp_ack.pop_front()) begin failures++; $display("FAIL timeout_ack: got juror %0d (%0d acks) want juror 1", o, obs_ack.size()); end
        checks++;
        if (done_at !== int'(TO) + 2) begin failures++; $display("FAIL timeout_done: got %0d want %0d", done_at, TO + 2); end
        r = exp_res.pop_front();
        checks++;
        if (obs_res !== r) begin failures++; $display("FAIL timeout_result: got %s want %s", rs(obs_res), rs(r)); end
    endtask

    task automatic test_timeout_grant();
        logic [2*N-1:0] codes;
        int             exp_c[$];
        int             e, o, c, sum;
        res_t           r;
        codes = {2'b01, 2'b01, 2'b01, 2'b10};
        exp_ack = '{0, 1, 2, 3};
        exp_c   = '{2, 3, 4, int'(TO) + 1};
        exp_res.push_back(model(codes, 4'b1111));
        run_round(4'b0111, codes, '0, 3, int'(TO), 40);
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            o = (obs_ack.size() > 0) ? obs_ack.pop_front() : -1;
            c = (obs_cyc.size() > 0) ? obs_cyc.pop_front() : -1;
            checks++;
            if (o !== e || c !== exp_c[0]) begin
                failures++; $display("FAIL tgrant_ack: got juror %0d at %0d want juror %0d at %0d", o, c, e, exp_c[0]);
            end
            void'(exp_c.pop_front());
        end
        checks++;
        if (done_at !== int'(TO) + 2) begin failures++; $display("FAIL tgrant_done: got %0d want %0d", done_at, TO + 2); end
        r = exp_res.pop_front();
        checks++;
        if (obs_res !== r) begin failures++; $display("FAIL tgrant_result: got %s want %s", rs(obs_res), rs(r)); end
        sum = int'(obs_res.y) + int'(obs_res.n) + int'(obs_res.a);
        checks++;
        if (sum !== int'(N)) begin failures++; $display("FAIL tgrant_sum: got %0d want %0d", sum, N); end
    endtask

    task automatic test_tie_invalid();
        logic [2*N-1:0] codes;
        res_t           r;
        codes = {2'b01, 2'b10, 2'b01, 2'b10};
        exp_res.push_back(model(codes, 4'b1111));
        run_round(4'b1111, codes, '0, -1, 0, 40);
        r = exp_res.pop_front();
        checks++;
        if (timed_out || obs_res !== r) begin failures++; $display("FAIL tie_result: got %s want %s", rs(obs_res), rs(r)); end
        codes = {2'b11, 2'b00, 2'b10, 2'b11};
        exp_res.push_back(model(codes, 4'b1111));
        run_round(4'b1111, codes, '0, -1, 0, 40);
        r = exp_res.pop_front();
        checks++;
        if (timed_out || obs_res !== r) begin failures++; $display("FAIL invalid_result: got %s want %s", rs(obs_res), rs(r)); end
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] codes;
        int             acks;
        res_t           r;
        codes = {2'b00, 2'b00, 2'b10, 2'b10};
        acks  = 0;
        @(negedge clk);
        vote_code = codes;
        vote_req  = 4'b0011;
        start     = 1'b1;
        for (int c = 1; c <= 10 && acks < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (vote_ack != '0) begin acks++; vote_req = vote_req & ~vote_ack; end
        end
        checks++;
        if (acks !== 2) begin failures++; $display("FAIL rstmid_acks: got %0d want 2", acks); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({vote_ack, voted, busy, done, yes_count, no_count, abst_count, verdict} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear: ack=%b voted=%b busy=%b done=%b %s", vote_ack, voted, busy, done, rs(cur_res()));
        end
        rst = 1'b0;
        vote_req = '0;
        codes = {2'b10, 2'b00, 2'b01, 2'b10};
        exp_ack = '{0};
        exp_res.push_back(model(codes, 4'b1111));
        run_round(4'b1111, codes, '0, -1, 0, 40);
        checks++;
        if (obs_ack.size() == 0 || obs_ack[0] !== exp_ack.pop_front()) begin
            failures++; $display("FAIL rstmid_first: got juror %0d want juror 0", (obs_ack.size() > 0) ? obs_ack[0] : -1);
        end
        r = exp_res.pop_front();
        checks++;
        if (timed_out || obs_res !== r) begin failures++; $display("FAIL rstmid_result: got %s want %s", rs(obs_res), rs(r)); end
    endtask

    task automatic test_start_ignored();
        logic [2*N-1:0] codes;
        int             d_at;
        res_t           r;
        codes = {2'b00, 2'b00, 2'b00, 2'b10};
        r     = model(codes, 4'b0001);
        d_at  = -1;
        @(negedge clk);
        vote_code = codes;
        vote_req  = 4'b0001;
        start     = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (vote_ack != '0) begin
                vote_req = '0;
                start    = 1'b1;
            end
            if (c == 3) begin
                checks++;
                if (voted !== 4'b0001 || busy !== 1'b1) begin
                    failures++; $display("FAIL busy_start: got voted=%b busy=%b want voted=0001 busy=1", voted, busy);
                end
            end
            if (done) begin d_at = c; break; end
        end
        checks++;
        if (d_at !== int'(TO) + 2) begin failures++; $display("FAIL busy_start_done: got %0d want %0d", d_at, TO + 2); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cur_res() !== r) begin
            failures++; $display("FAIL done_start: got busy=%b done=%b %s want busy=0 done=0 %s", busy, done, rs(cur_res()), rs(r));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rehold();
        test_timeout();
        test_timeout_grant();
        test_tie_invalid();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jury_vote_controller.md
# jury_vote_controller

Sequences one voting round of the jury panel. Each juror presents a 2-bit vote code (S1,S0) and a request; the block round-robin arbitrates the requests, accepts exactly one vote per juror per round, tallies the votes, and publishes counts plus a verdict. It sits between the per-juror input circuits and the score/display logic, and is the only writer of round results.

## Interface

Parameters:
- N_JURORS, 4, number of jurors (2..8)
- TIMEOUT, 200, COLLECT-state cycles before the round closes
- CW, $clog2(N_JURORS+1), count width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  open a round; honoured only in IDLE
- vote_req  in  N_JURORS  per-juror request, held until acked
- vote_code  in  2*N_JURORS  juror i code at [2i+1:2i]: 10 favour, 01 against, 00 abstain, 11 invalid (= abstain)
- vote_ack  out  N_JURORS  one-hot, 1-cycle acceptance pulse
- voted  out  N_JURORS  mask of jurors accepted this round
- busy  out  1  high in COLLECT and TALLY
- done  out  1  1-cycle pulse when results are valid
- yes_count, no_count, abst_count  out  CW each  tallies
- verdict  out  2  10 approved, 01 rejected, 00 tie/none

## Operation

- FSM states: IDLE, COLLECT, TALLY, DONE.
- IDLE: start=1 → clear counts, voted, timer, and verdict; go to COLLECT. Results from the previous round hold until then.
- COLLECT:
  - eligible = vote_req & ~voted.
  - The round-robin arbiter grants one eligible juror per cycle. Priority starts at the index after the last grant; juror 0 has first priority after reset/start.
  - On a grant: pulse vote_ack[i], set voted[i], and increment yes, no, or abst per vote_code[i] sampled in the grant cycle.
  - A juror's requests after acceptance are ignored for the rest of the round.
- Exit COLLECT when voted is all-ones, or when timer == TIMEOUT-1.
  - If a grant and the timeout occur in the same cycle, the grant is counted.
- TALLY (1 cycle):
  - abst_count += number of jurors not in voted.
  - verdict = 10 if yes > no, 01 if no > yes, else 00.
- DONE (1 cycle): done=1; next state IDLE.
- start while busy or in DONE: ignored.
- Invariant at done: yes + no + abst == N_JURORS.
- rst at any time: all outputs 0, state IDLE, arbiter pointer to juror 0. An in-progress round is discarded.

## Timing

- Reset values: vote_ack, voted, busy, done, all counts, and verdict = 0.
- start sampled at edge t → busy=1 from t+1.
- Request sampled at edge t → vote_ack and count updates are visible after edge t+1 (registered outputs, 1-cycle latency).
  - Maximum throughput is 1 vote per cycle.
- Requester must hold vote_req and vote_code stable until vote_ack is seen; vote_code is sampled only in the grant cycle.
- Last vote accepted at cycle k → TALLY at k+1, done pulse at k+2, IDLE at k+3. Earliest next start is accepted in IDLE.
- Timeout path: COLLECT lasts exactly TIMEOUT cycles if not all jurors vote.
- Counts never wrap: CW holds N_JURORS.

## Structure

- Shared header/package: vote code constants, verdict codes, FSM state encoding, CW derivation.
- One sub-module: rr_arbiter (N-bit request in, one-hot grant out, pointer update on grant enable). Everything else lives in jury_vote_controller.

## Test plan

- rst, start, all 4 jurors request simultaneously with codes 10,10,01,00 → acks in order 0,1,2,3 on consecutive cycles; yes=2, no=1, abst=1, verdict=10; done 2 cycles after last ack.
- Juror 2 holds vote_req after its ack while juror 0 requests late → juror 2 is never re-acked; only juror 0 is acked; voted mask is correct.
- TIMEOUT=10, only juror 1 votes 01 → done at cycle 10+2; no=1, abst=3, verdict=01.
- Last grant in the timeout cycle → vote counted; totals sum to 4.
- Two favour and two against → verdict=00. Also drive code 11 → counted as abstain.
- rst asserted mid-COLLECT with 2 votes in → all outputs 0 next cycle; start during busy is ignored; a new round starts cleanly.
